// File: rtl/sccb_cmd_arbiter.sv
// sccb_cmd_arbiter
//   Shares one SCCB register-write master between two requesters:
//   port 0 (boot-time camera init sequencer) and port 1 (runtime
//   reconfiguration). One addr/data write is arbitrated, latched and driven
//   through the master's ready/busy handshake at a time. The reserved pair
//   {DelayAddr, DelayData} is not written to the bus; it becomes a timed
//   wait of DelayCycles clocks instead.
//
//   Optional macro SCCB_RR_EN: round-robin arbitration between the two
//   ports (default build: fixed priority, port 0 wins a tie).
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   i_req[1:0]        per-port request, held until the matching o_ack bit
//   i_addr0/i_data0   port 0 register address/data
//   i_addr1/i_data1   port 1 register address/data
//   o_ack[1:0]        1-cycle pulse: that port's command was latched
//   o_done[1:0]       1-cycle pulse: that port's command finished
//   o_error           1-cycle pulse: master never accepted, command dropped
//   o_busy            high while the FSM is not IDLE
//   o_grant           port id owning the current command
//   o_sccb_addr/data  latched command towards the SCCB master
//   o_sccb_ready      command-valid towards the SCCB master
//   i_sccb_busy       SCCB master busy
//
// State | meaning
// IDLE  | waiting for a request while the master is idle
// ISSUE | o_sccb_ready high, waiting for the master to raise busy
// RUN   | master accepted, waiting for busy to fall
// DELAY | delay token latched, counting DelayCycles

module sccb_cmd_arbiter #(
  parameter int unsigned DelayCycles   = 500_000,
  parameter int unsigned AcceptTimeout = 1024,
  parameter logic [7:0]  DelayAddr     = 8'hFF,
  parameter logic [7:0]  DelayData     = 8'hFF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] i_req,
  input  logic [7:0] i_addr0,
  input  logic [7:0] i_data0,
  input  logic [7:0] i_addr1,
  input  logic [7:0] i_data1,
  output logic [1:0] o_ack,
  output logic [1:0] o_done,
  output logic       o_error,
  output logic       o_busy,
  output logic       o_grant,
  output logic [7:0] o_sccb_addr,
  output logic [7:0] o_sccb_data,
  output logic       o_sccb_ready,
  input  logic       i_sccb_busy
);

  localparam int unsigned TMax = (DelayCycles > AcceptTimeout) ? DelayCycles : AcceptTimeout;
  localparam int TW = $clog2(TMax) + 1;
  localparam logic [TW-1:0] DelayLast  = TW'(DelayCycles - 1);
  localparam logic [TW-1:0] AcceptLast = TW'(AcceptTimeout - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DELAY = 2'd3;

  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic          win;
  logic [7:0]    sel_addr;
  logic [7:0]    sel_data;

`ifdef SCCB_RR_EN
  logic last_served;

  // On a tie the port that was not served last wins; a lone requester always wins.
  always_comb begin
    win = 1'b0;
    if (i_req[0] && i_req[1]) win = ~last_served;
    else                      win = ~i_req[0];
  end
`else
  always_comb begin
    win = ~i_req[0];
  end
`endif

  assign sel_addr = win ? i_addr1 : i_addr0;
  assign sel_data = win ? i_data1 : i_data0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      timer        <= '0;
      o_ack        <= '0;
      o_done       <= '0;
      o_error      <= 1'b0;
      o_busy       <= 1'b0;
      o_grant      <= 1'b0;
      o_sccb_addr  <= '0;
      o_sccb_data  <= '0;
      o_sccb_ready <= 1'b0;
`ifdef SCCB_RR_EN
      last_served  <= 1'b1;
`endif
    end else begin
      o_ack   <= '0;
      o_done  <= '0;
      o_error <= 1'b0;
      case (state)
        IDLE: begin
          if ((|i_req) && !i_sccb_busy) begin
            o_sccb_addr <= sel_addr;
            o_sccb_data <= sel_data;
            o_grant     <= win;
            o_ack       <= win ? 2'b10 : 2'b01;
            o_busy      <= 1'b1;
            timer       <= '0;
`ifdef SCCB_RR_EN
            last_served <= win;
`endif
            if (sel_addr == DelayAddr && sel_data == DelayData) begin
              state <= DELAY;
            end else begin
              state        <= ISSUE;
              o_sccb_ready <= 1'b1;
            end
          end
        end
        ISSUE: begin
          // o_sccb_ready is always high here, so busy alone means accepted.
          if (i_sccb_busy) begin
            o_sccb_ready <= 1'b0;
            state        <= RUN;
          end else if (timer == AcceptLast) begin
            o_sccb_ready <= 1'b0;
            o_error      <= 1'b1;
            o_busy       <= 1'b0;
            state        <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RUN: begin
          if (!i_sccb_busy) begin
            o_done <= o_grant ? 2'b10 : 2'b01;
            o_busy <= 1'b0;
            state  <= IDLE;
          end
        end
        DELAY: begin
          if (timer == DelayLast) begin
            o_done <= o_grant ? 2'b10 : 2'b01;
            o_busy <= 1'b0;
            state  <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
